// File: rtl/led_sequencer_if.sv
// Command port of the LED sequencer: valid/ready handshake carrying mode, pattern and duty.
interface led_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_mode;
   logic [4:0] cmd_pattern;
   logic [3:0] cmd_duty;

   modport master (
      output cmd_valid,
      output cmd_mode,
      output cmd_pattern,
      output cmd_duty,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_mode,
      input  cmd_pattern,
      input  cmd_duty,
      output cmd_ready
   );
endinterface

// File: rtl/led_sequencer.sv
// Five-LED pattern sequencer (static/blink/chase/bounce) with a prescaled step rate.
// Optional brightness PWM is enabled by defining LED_PWM_EN.
module led_sequencer #(
   parameter int unsigned CLK_HZ  = 12000000,
   parameter int unsigned STEP_HZ = 4
) (
   input  logic              clk,
   input  logic              rstn,
   led_sequencer_if.slave    cmd_if,
   output logic              step,
   output logic              D1,
   output logic              D2,
   output logic              D3,
   output logic              D4,
   output logic              D5
);
   localparam int unsigned DIV = CLK_HZ / STEP_HZ;
   localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [1:0] ModeStatic = 2'b00;
   localparam logic [1:0] ModeBlink  = 2'b01;
   localparam logic [1:0] ModeChase  = 2'b10;
   localparam logic [1:0] ModeBounce = 2'b11;
   localparam logic       DirLeft    = 1'b0;
   localparam logic       DirRight   = 1'b1;

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   state_e          r_state, w_state_d;
   logic            w_accept, w_tick, w_ready;
   logic [PW-1:0]   r_pre, w_pre_d;
   logic [4:0]      r_shown, w_shown_d;
   logic [4:0]      r_cmd_pattern;
   logic [1:0]      r_cmd_mode;
   logic [1:0]      r_mode, w_mode_d;
   logic            r_dir, w_dir_d;
   logic            r_phase, w_phase_d;
   logic            r_step, w_step_d;
   logic [4:0]      w_disp_d, w_led_d, r_led;

   assign w_accept = cmd_if.cmd_valid & w_ready;
   assign w_tick   = (r_state == StRun) && (r_pre == PW'(DIV - 1));

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= StIdle;
      else       r_state <= w_state_d;
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_d = StLoad;
         StLoad:  w_state_d = StRun;
         StRun:   if (w_accept) w_state_d = StLoad;
         default: w_state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      w_ready = (r_state != StLoad);
   end
   assign cmd_if.cmd_ready = w_ready;

   // Animation datapath; an accept in RUN discards a coincident tick update.
   always_comb begin
      w_shown_d = r_shown;
      w_mode_d  = r_mode;
      w_dir_d   = r_dir;
      w_phase_d = r_phase;
      w_pre_d   = r_pre;
      w_step_d  = 1'b0;
      case (r_state)
         StLoad: begin
            w_shown_d = r_cmd_pattern;
            w_mode_d  = r_cmd_mode;
            w_dir_d   = DirLeft;
            w_phase_d = 1'b1;
            w_pre_d   = '0;
         end
         StRun: begin
            if (!w_accept) begin
               if (w_tick) begin
                  w_pre_d   = '0;
                  w_step_d  = 1'b1;
                  w_phase_d = ~r_phase;
                  case (r_mode)
                     ModeChase: w_shown_d = {r_shown[3:0], r_shown[4]};
                     ModeBounce: begin
                        if (r_shown == 5'b0 || (r_shown[4] && r_shown[0])) begin
                           w_shown_d = r_shown;
                        end else if (r_dir == DirLeft) begin
                           if (r_shown[4]) begin
                              w_dir_d   = DirRight;
                              w_shown_d = {1'b0, r_shown[4:1]};
                           end else begin
                              w_shown_d = {r_shown[3:0], 1'b0};
                           end
                        end else begin
                           if (r_shown[0]) begin
                              w_dir_d   = DirLeft;
                              w_shown_d = {r_shown[3:0], 1'b0};
                           end else begin
                              w_shown_d = {1'b0, r_shown[4:1]};
                           end
                        end
                     end
                     default: w_shown_d = r_shown;
                  endcase
               end else begin
                  w_pre_d = r_pre + PW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_disp_d = w_shown_d;
      if (w_state_d == StIdle) begin
         w_disp_d = 5'b0;
      end else if (w_mode_d == ModeBlink && !w_phase_d) begin
         w_disp_d = 5'b0;
      end
   end

`ifdef LED_PWM_EN
   logic [3:0] r_pwm_cnt, r_duty, r_cmd_duty, w_duty_d;
   logic       w_gate;

   assign w_duty_d = (r_state == StLoad) ? r_cmd_duty : r_duty;
   assign w_gate   = (r_pwm_cnt < w_duty_d);
   assign w_led_d  = w_disp_d & {5{w_gate}};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pwm_cnt  <= 4'd0;
         r_duty     <= 4'd0;
         r_cmd_duty <= 4'd0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 4'd1;
         r_duty    <= w_duty_d;
         if (w_accept) r_cmd_duty <= cmd_if.cmd_duty;
      end
   end
`else
   assign w_led_d = w_disp_d;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_shown       <= 5'b0;
         r_mode        <= ModeStatic;
         r_dir         <= DirLeft;
         r_phase       <= 1'b1;
         r_pre         <= '0;
         r_step        <= 1'b0;
         r_led         <= 5'b0;
         r_cmd_pattern <= 5'b0;
         r_cmd_mode    <= ModeStatic;
      end else begin
         r_shown <= w_shown_d;
         r_mode  <= w_mode_d;
         r_dir   <= w_dir_d;
         r_phase <= w_phase_d;
         r_pre   <= w_pre_d;
         r_step  <= w_step_d;
         r_led   <= w_led_d;
         if (w_accept) begin
            r_cmd_pattern <= cmd_if.cmd_pattern;
            r_cmd_mode    <= cmd_if.cmd_mode;
         end
      end
   end

   assign step = r_step;
   assign D1   = r_led[0];
   assign D2   = r_led[1];
   assign D3   = r_led[2];
   assign D4   = r_led[3];
   assign D5   = r_led[4];
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with DIV=4 (CLK_HZ=40, STEP_HZ=10).
module tb_led_sequencer;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic step;
   logic D1, D2, D3, D4, D5;
   logic [4:0] leds;
   int total = 0;
   int bad = 0;

   led_sequencer_if cmd_bus ();

   led_sequencer #(.CLK_HZ(40), .STEP_HZ(10)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .cmd_if (cmd_bus),
      .step   (step),
      .D1     (D1),
      .D2     (D2),
      .D3     (D3),
      .D4     (D4),
      .D5     (D5)
   );

   assign leds = {D5, D4, D3, D2, D1};

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Presents a command for one edge (accept at edge k), returns just after edge k+1.
   task automatic send(input logic [1:0] m, input logic [4:0] p, input logic [3:0] d);
      cmd_bus.cmd_valid   = 1'b1;
      cmd_bus.cmd_mode    = m;
      cmd_bus.cmd_pattern = p;
      cmd_bus.cmd_duty    = d;
      cycle();
      cmd_bus.cmd_valid   = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      total++;
      if (leds !== 5'b0 || cmd_bus.cmd_ready !== 1'b1 || step !== 1'b0) begin
         bad++;
         $display("FAIL reset_vals: leds=%b ready=%b step=%b required 00000/1/0",
                  leds, cmd_bus.cmd_ready, step);
      end
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         total++;
         if (leds !== 5'b0 || cmd_bus.cmd_ready !== 1'b1 || step !== 1'b0) begin
            bad++;
            $display("FAIL idle_%0d: leds=%b ready=%b step=%b required 00000/1/0",
                     i, leds, cmd_bus.cmd_ready, step);
         end
      end
   endtask

   task automatic test_static();
      cmd_bus.cmd_valid   = 1'b1;
      cmd_bus.cmd_mode    = 2'b00;
      cmd_bus.cmd_pattern = 5'b10101;
      cmd_bus.cmd_duty    = 4'd15;
      cycle();
      cmd_bus.cmd_valid = 1'b0;
      total++;
      if (cmd_bus.cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL static_ready_load: got %b required 0", cmd_bus.cmd_ready);
      end
      cycle();
      total++;
      if (leds !== 5'b10101 || cmd_bus.cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL static_show: leds=%b ready=%b required 10101/1", leds, cmd_bus.cmd_ready);
      end
      // Edges k+2..k+9; steps expected at k+5 and k+9.
      for (int e = 2; e <= 9; e++) begin
         cycle();
         total++;
         if (step !== ((e == 5) || (e == 9)) || leds !== 5'b10101 || cmd_bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL static_edge_k+%0d: step=%b leds=%b ready=%b required %b/10101/1",
                     e, step, leds, cmd_bus.cmd_ready, (e == 5) || (e == 9));
         end
      end
   endtask

   task automatic test_chase();
      logic [4:0] exp_seq [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      send(2'b10, 5'b00001, 4'd0);
      total++;
      if (leds !== 5'b00001) begin
         bad++;
         $display("FAIL chase_load: leds=%b required 00001", leds);
      end
      for (int t = 0; t < 5; t++) begin
         for (int j = 0; j < 3; j++) begin
            cycle();
            total++;
            if (step !== 1'b0) begin
               bad++;
               $display("FAIL chase_gap_%0d_%0d: step=%b required 0", t, j, step);
            end
         end
         cycle();
         total++;
         if (step !== 1'b1 || leds !== exp_seq[t]) begin
            bad++;
            $display("FAIL chase_tick_%0d: step=%b leds=%b required 1/%b", t, step, leds, exp_seq[t]);
         end
      end
   endtask

   task automatic test_bounce();
      logic [4:0] exp_seq [7] = '{5'b00110, 5'b01100, 5'b11000, 5'b01100, 5'b00110,
                                  5'b00011, 5'b00110};
      send(2'b11, 5'b00011, 4'd0);
      total++;
      if (leds !== 5'b00011) begin
         bad++;
         $display("FAIL bounce_load: leds=%b required 00011", leds);
      end
      for (int t = 0; t < 7; t++) begin
         repeat (4) cycle();
         total++;
         if (step !== 1'b1 || leds !== exp_seq[t]) begin
            bad++;
            $display("FAIL bounce_tick_%0d: step=%b leds=%b required 1/%b", t, step, leds, exp_seq[t]);
         end
      end
      send(2'b11, 5'b10001, 4'd0);
      for (int t = 0; t < 3; t++) begin
         repeat (4) cycle();
         total++;
         if (step !== 1'b1 || leds !== 5'b10001) begin
            bad++;
            $display("FAIL bounce_hold_%0d: step=%b leds=%b required 1/10001", t, step, leds);
         end
      end
   endtask

   task automatic test_blink_preempt();
      logic [4:0] exp_seq [3] = '{5'b00000, 5'b01010, 5'b00000};
      send(2'b01, 5'b01010, 4'd0);
      total++;
      if (leds !== 5'b01010) begin
         bad++;
         $display("FAIL blink_load: leds=%b required 01010", leds);
      end
      for (int t = 0; t < 3; t++) begin
         repeat (4) cycle();
         total++;
         if (step !== 1'b1 || leds !== exp_seq[t]) begin
            bad++;
            $display("FAIL blink_tick_%0d: step=%b leds=%b required 1/%b", t, step, leds, exp_seq[t]);
         end
      end
      // Next tick edge is 4 edges away; present CHASE so it is accepted on that edge.
      repeat (3) cycle();
      cmd_bus.cmd_valid   = 1'b1;
      cmd_bus.cmd_mode    = 2'b10;
      cmd_bus.cmd_pattern = 5'b00001;
      cycle();
      cmd_bus.cmd_valid = 1'b0;
      total++;
      if (cmd_bus.cmd_ready !== 1'b0 || leds !== 5'b00000) begin
         bad++;
         $display("FAIL preempt_tick_discard: ready=%b leds=%b required 0/00000",
                  cmd_bus.cmd_ready, leds);
      end
      cycle();
      total++;
      if (leds !== 5'b00001) begin
         bad++;
         $display("FAIL preempt_load: leds=%b required 00001", leds);
      end
      for (int j = 0; j < 3; j++) begin
         cycle();
         total++;
         if (step !== 1'b0 || leds !== 5'b00001) begin
            bad++;
            $display("FAIL preempt_gap_%0d: step=%b leds=%b required 0/00001", j, step, leds);
         end
      end
      cycle();
      total++;
      if (step !== 1'b1 || leds !== 5'b00010) begin
         bad++;
         $display("FAIL preempt_first_step: step=%b leds=%b required 1/00010", step, leds);
      end
   endtask

   task automatic test_async_reset();
      send(2'b10, 5'b00001, 4'd0);
      repeat (6) cycle();
      #3;
      rstn = 1'b0;
      #1;
      total++;
      if (leds !== 5'b0 || cmd_bus.cmd_ready !== 1'b1 || step !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: leds=%b ready=%b step=%b required 00000/1/0",
                  leds, cmd_bus.cmd_ready, step);
      end
      #10;
      rstn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         total++;
         if (leds !== 5'b0 || cmd_bus.cmd_ready !== 1'b1 || step !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle_%0d: leds=%b ready=%b step=%b required 00000/1/0",
                     i, leds, cmd_bus.cmd_ready, step);
         end
      end
      send(2'b00, 5'b00100, 4'd15);
      total++;
      if (leds !== 5'b00100) begin
         bad++;
         $display("FAIL post_reset_cmd: leds=%b required 00100", leds);
      end
   endtask

`ifdef LED_PWM_EN
   task automatic test_pwm();
      int on_cnt;
      send(2'b00, 5'b11111, 4'd4);
      on_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         cycle();
         if (D1) on_cnt++;
      end
      total++;
      if (on_cnt != 8) begin
         bad++;
         $display("FAIL pwm_duty4: on=%0d of 32 required 8", on_cnt);
      end
      send(2'b00, 5'b11111, 4'd0);
      on_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         cycle();
         if (leds != 5'b0) on_cnt++;
      end
      total++;
      if (on_cnt != 0) begin
         bad++;
         $display("FAIL pwm_duty0: lit cycles=%0d required 0", on_cnt);
      end
   endtask
`endif

   initial begin
      cmd_bus.cmd_valid   = 1'b0;
      cmd_bus.cmd_mode    = 2'b00;
      cmd_bus.cmd_pattern = 5'b0;
      cmd_bus.cmd_duty    = 4'd15;
      test_reset();
      test_static();
      test_chase();
      test_bounce();
      test_blink_preempt();
      test_async_reset();
`ifdef LED_PWM_EN
      test_pwm();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
